// File: rtl/vga_timing_addr_gen.sv
// vga_timing_addr_gen: VGA sync/blank timing with scaled framebuffer window address generation.
// Define DBL_BUF_EN to enable double buffering (buffer select prepended as the address MSB).
module vga_timing_addr_gen #(
   parameter int unsigned PIX_DIV  = 2,
   parameter int unsigned H_ACT    = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACT    = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned SYNC_POL = 0,
   parameter int unsigned FB_W     = 640,
   parameter int unsigned FB_H     = 480,
   parameter int unsigned SCALE    = 1,
   parameter int unsigned WIN_X0   = 0,
   parameter int unsigned WIN_Y0   = 0,
   parameter int unsigned RD_LAT   = 1,
   parameter int unsigned ADDR_W   = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              swap_req,
   output logic              swap_ack,
   output logic              buf_sel,
   output logic              pixel_clk_out,
   output logic              Hsync_out,
   output logic              Vsync_out,
   output logic              nblanck,
   output logic              nsync,
   output logic              display_EN,
   output logic              black_flag,
   output logic [ADDR_W-1:0] framebuff_addr,
   output logic              frame_start
);

   localparam int unsigned H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW    = $clog2(H_TOT + 1);
   localparam int unsigned VW    = $clog2(V_TOT + 1);
   localparam int unsigned DW    = $clog2(PIX_DIV);
   localparam int unsigned SW    = (SCALE > 1) ? $clog2(SCALE) : 1;
`ifdef DBL_BUF_EN
   localparam int unsigned LW    = ADDR_W - 1;
`else
   localparam int unsigned LW    = ADDR_W;
`endif
   // Window bounds clipped to the active area
   localparam int unsigned WX0   = (WIN_X0 < H_ACT) ? WIN_X0 : H_ACT;
   localparam int unsigned WX1   = (WIN_X0 + FB_W * SCALE < H_ACT) ? WIN_X0 + FB_W * SCALE : H_ACT;
   localparam int unsigned WY0   = (WIN_Y0 < V_ACT) ? WIN_Y0 : V_ACT;
   localparam int unsigned WY1   = (WIN_Y0 + FB_H * SCALE < V_ACT) ? WIN_Y0 + FB_H * SCALE : V_ACT;
   localparam int unsigned HS0   = H_ACT + H_FP;
   localparam int unsigned HS1   = HS0 + H_SYNC;
   localparam int unsigned VS0   = V_ACT + V_FP;
   localparam int unsigned VS1   = VS0 + V_SYNC;
   localparam int unsigned DEPTH = RD_LAT + 1;
   localparam logic        SYNC_ON  = 1'(SYNC_POL);
   localparam logic        SYNC_OFF = ~SYNC_ON;
   // Pipeline stage layout: {active, black, hsync, vsync}
   localparam logic [3:0]  PIPE_RST = {1'b0, 1'b1, SYNC_OFF, SYNC_OFF};

   logic [DW-1:0]     div_q, div_d;
   logic [HW-1:0]     h_q, h_d;
   logic [VW-1:0]     v_q, v_d;
   logic [LW-1:0]     col_q, col_d, row_q, row_d, lin_c;
   logic [SW-1:0]     subx_q, subx_d, suby_q, suby_d;
   logic [ADDR_W-1:0] addr_q, addr_d, win_addr_c;
   logic              pclk_q, pclk_d, fs_q, fs_d;
   logic              buf_q, buf_d, ack_q, ack_d;
   logic              pix_ce_c, h_end_c, v_end_c, ge_x0_c, ge_y0_c;
   logic              in_x_c, in_y_c, in_win_c, active_c;
   logic [3:0]        stage_c, pipe_out_c;

   // Lower window edge compare, elided when the window starts at the screen edge
   if (WX0 == 0) begin : g_x0_zero
      assign ge_x0_c = 1'b1;
   end else begin : g_x0_cmp
      assign ge_x0_c = (h_q >= HW'(WX0));
   end
   if (WY0 == 0) begin : g_y0_zero
      assign ge_y0_c = 1'b1;
   end else begin : g_y0_cmp
      assign ge_y0_c = (v_q >= VW'(WY0));
   end

   // Position decode for the current (h, v)
   always_comb begin
      pix_ce_c = (div_q == DW'(PIX_DIV - 1));
      h_end_c  = (h_q == HW'(H_TOT - 1));
      v_end_c  = (v_q == VW'(V_TOT - 1));
      in_x_c   = ge_x0_c && (h_q < HW'(WX1));
      in_y_c   = ge_y0_c && (v_q < VW'(WY1));
      in_win_c = in_x_c && in_y_c;
      active_c = (h_q < HW'(H_ACT)) && (v_q < VW'(V_ACT));
      lin_c    = row_q + col_q;
      stage_c  = {active_c, ~in_win_c,
                  ((h_q >= HW'(HS0)) && (h_q < HW'(HS1))) ? SYNC_ON : SYNC_OFF,
                  ((v_q >= VW'(VS0)) && (v_q < VW'(VS1))) ? SYNC_ON : SYNC_OFF};
   end

`ifdef DBL_BUF_EN
   assign win_addr_c = {buf_q, lin_c};
`else
   assign win_addr_c = lin_c;
`endif

   // Next state for counters, incremental address and registered strobes
   always_comb begin
      div_d  = pix_ce_c ? '0 : div_q + DW'(1);
      h_d    = h_q;
      v_d    = v_q;
      col_d  = col_q;
      subx_d = subx_q;
      row_d  = row_q;
      suby_d = suby_q;
      addr_d = addr_q;
      pclk_d = (div_q >= DW'(PIX_DIV / 2));
      fs_d   = 1'b0;
      if (pix_ce_c) begin
         h_d    = h_end_c ? '0 : h_q + HW'(1);
         addr_d = in_win_c ? win_addr_c : '0;
         fs_d   = h_end_c && (v_q == VW'(VS0 - 1));
         if (h_end_c) begin
            v_d = v_end_c ? '0 : v_q + VW'(1);
         end
         if (in_win_c) begin
            if (subx_q == SW'(SCALE - 1)) begin
               subx_d = '0;
               col_d  = col_q + LW'(1);
            end else begin
               subx_d = subx_q + SW'(1);
            end
         end else begin
            subx_d = '0;
            col_d  = '0;
         end
         if (h_end_c) begin
            if (in_y_c) begin
               if (suby_q == SW'(SCALE - 1)) begin
                  suby_d = '0;
                  row_d  = row_q + LW'(FB_W);
               end else begin
                  suby_d = suby_q + SW'(1);
               end
            end else begin
               suby_d = '0;
               row_d  = '0;
            end
         end
      end
   end

`ifdef DBL_BUF_EN
   logic pend_q, pend_d;

   // Swap request latch; swap taken at frame start including a same-cycle request
   always_comb begin
      buf_d  = buf_q;
      ack_d  = 1'b0;
      pend_d = pend_q | swap_req;
      if (fs_q && (pend_q || swap_req)) begin
         buf_d  = ~buf_q;
         ack_d  = 1'b1;
         pend_d = 1'b0;
      end
   end

   // Pending swap register
   always_ff @(posedge clk) begin
      if (rst) pend_q <= 1'b0;
      else     pend_q <= pend_d;
   end
`else
   logic swap_req_unused;

   // Single buffer: no swaps
   always_comb begin
      buf_d           = 1'b0;
      ack_d           = 1'b0;
      swap_req_unused = swap_req;
   end
`endif

   // Main state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q  <= '0;
         h_q    <= '0;
         v_q    <= '0;
         col_q  <= '0;
         subx_q <= '0;
         row_q  <= '0;
         suby_q <= '0;
         addr_q <= '0;
         pclk_q <= 1'b0;
         fs_q   <= 1'b0;
         buf_q  <= 1'b0;
         ack_q  <= 1'b0;
      end else begin
         div_q  <= div_d;
         h_q    <= h_d;
         v_q    <= v_d;
         col_q  <= col_d;
         subx_q <= subx_d;
         row_q  <= row_d;
         suby_q <= suby_d;
         addr_q <= addr_d;
         pclk_q <= pclk_d;
         fs_q   <= fs_d;
         buf_q  <= buf_d;
         ack_q  <= ack_d;
      end
   end

   // Sync/blank alignment pipeline: one stage for the address register plus RD_LAT
   for (genvar g = 0; g < DEPTH; g++) begin : g_pipe
      logic [3:0] q;
      if (g == 0) begin : g_head
         // Capture decode of the current pixel
         always_ff @(posedge clk) begin
            if (rst)           q <= PIPE_RST;
            else if (pix_ce_c) q <= stage_c;
         end
      end else begin : g_tail
         // Delay by one pixel
         always_ff @(posedge clk) begin
            if (rst)           q <= PIPE_RST;
            else if (pix_ce_c) q <= g_pipe[g-1].q;
         end
      end
   end
   assign pipe_out_c = g_pipe[DEPTH-1].q;

   assign pixel_clk_out  = pclk_q;
   assign framebuff_addr = addr_q;
   assign frame_start    = fs_q;
   assign buf_sel        = buf_q;
   assign swap_ack       = ack_q;
   assign display_EN     = pipe_out_c[3];
   assign nblanck        = pipe_out_c[3];
   assign black_flag     = pipe_out_c[2];
   assign Hsync_out      = pipe_out_c[1];
   assign Vsync_out      = pipe_out_c[0];
   assign nsync          = 1'b0;

endmodule

// File: tb/tb_vga_timing_addr_gen.sv
// Testbench for vga_timing_addr_gen: small-mode instance checked every clock against a
// position-based reference model; random swap requests and a random mid-line reset.
module tb_vga_timing_addr_gen;

   localparam int PIX_DIV = 2;
   localparam int H_ACT = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
   localparam int V_ACT = 10, V_FP = 1, V_SYNC = 2, V_BP = 2;
   localparam int SYNC_POL = 0;
   localparam int FB_W = 5, FB_H = 3, SCALE = 2;
   localparam int WIN_X0 = 8, WIN_Y0 = 5;
   localparam int RD_LAT = 2;
   localparam int ADDR_W = 5;
   localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
`ifdef DBL_BUF_EN
   localparam bit DBL = 1'b1;
`else
   localparam bit DBL = 1'b0;
`endif

   logic              clk, rst, swap_req;
   logic              swap_ack, buf_sel, pixel_clk_out, Hsync_out, Vsync_out;
   logic              nblanck, nsync, display_EN, black_flag, frame_start;
   logic [ADDR_W-1:0] framebuff_addr;

   vga_timing_addr_gen #(
      .PIX_DIV(PIX_DIV), .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .SYNC_POL(SYNC_POL),
      .FB_W(FB_W), .FB_H(FB_H), .SCALE(SCALE), .WIN_X0(WIN_X0), .WIN_Y0(WIN_Y0),
      .RD_LAT(RD_LAT), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst(rst), .swap_req(swap_req), .swap_ack(swap_ack), .buf_sel(buf_sel),
      .pixel_clk_out(pixel_clk_out), .Hsync_out(Hsync_out), .Vsync_out(Vsync_out),
      .nblanck(nblanck), .nsync(nsync), .display_EN(display_EN), .black_flag(black_flag),
      .framebuff_addr(framebuff_addr), .frame_start(frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   function automatic bit in_win(input int h, input int v);
      return (h >= WIN_X0) && (h < WIN_X0 + FB_W * SCALE) && (h < H_ACT) &&
             (v >= WIN_Y0) && (v < WIN_Y0 + FB_H * SCALE) && (v < V_ACT);
   endfunction

   function automatic int win_addr(input int h, input int v, input int b);
      if (!in_win(h, v)) return 0;
      return ((v - WIN_Y0) / SCALE) * FB_W + (h - WIN_X0) / SCALE + (DBL ? (b << (ADDR_W - 1)) : 0);
   endfunction

   // Model state: clocks since reset, swap bookkeeping, expected outputs
   int n = 0, pend_m = 0, buf_m = 0, ack_m = 0;
   bit started = 0, rst_m = 0;
   bit e_pclk, e_fs, e_de, e_blk, e_hs, e_vs;
   int e_addr, cur_h, cur_v;
   bit hs_prev = 1'b1, have_fall = 0, low_valid = 0;
   int gap = 0, low_cnt = 0;

   // Reference model step and per-clock compare
   always @(posedge clk) begin
      int p, q, h, v;
      rst_m = rst;
      if (rst) begin
         started = 1;
         n = 0; pend_m = 0; buf_m = 0; ack_m = 0;
      end else if (started) begin
         if (DBL) begin
            if (e_fs && (pend_m != 0 || swap_req)) begin
               buf_m = 1 - buf_m; ack_m = 1; pend_m = 0;
            end else begin
               ack_m = 0;
               if (swap_req) pend_m = 1;
            end
         end
         n++;
      end
      p = n / PIX_DIV;
      e_pclk = (n >= 1) && (((n - 1) % PIX_DIV) >= PIX_DIV / 2);
      e_fs   = (n > 0) && (n % PIX_DIV == 0) && (p % H_TOT == 0) && ((p / H_TOT) % V_TOT == V_ACT + V_FP);
      cur_h = -1; cur_v = -1;
      if (p >= 1) begin
         q = p - 1; h = q % H_TOT; v = (q / H_TOT) % V_TOT;
         e_addr = win_addr(h, v, buf_m);
         cur_h = h; cur_v = v;
      end else e_addr = 0;
      if (p >= 1 + RD_LAT) begin
         q = p - 1 - RD_LAT; h = q % H_TOT; v = (q / H_TOT) % V_TOT;
         e_de  = (h < H_ACT) && (v < V_ACT);
         e_blk = !in_win(h, v);
         e_hs  = (h >= H_ACT + H_FP && h < H_ACT + H_FP + H_SYNC) ? 1'(SYNC_POL) : !1'(SYNC_POL);
         e_vs  = (v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SYNC) ? 1'(SYNC_POL) : !1'(SYNC_POL);
      end else begin
         e_de = 0; e_blk = 1; e_hs = !1'(SYNC_POL); e_vs = !1'(SYNC_POL);
      end
      #1;
      if (started) begin
         check("pixel_clk_out", 32'(pixel_clk_out), 32'(e_pclk));
         check("framebuff_addr", 32'(framebuff_addr), 32'(e_addr));
         check("display_EN", 32'(display_EN), 32'(e_de));
         check("nblanck", 32'(nblanck), 32'(e_de));
         check("black_flag", 32'(black_flag), 32'(e_blk));
         check("Hsync_out", 32'(Hsync_out), 32'(e_hs));
         check("Vsync_out", 32'(Vsync_out), 32'(e_vs));
         check("frame_start", 32'(frame_start), 32'(e_fs));
         check("swap_ack", 32'(swap_ack), 32'(ack_m));
         check("buf_sel", 32'(buf_sel), 32'(buf_m));
         check("nsync", 32'(nsync), 32'd0);
         // Hand-computed address pins, once per pixel
         if (n % PIX_DIV == 0) begin
            if (cur_h == 8  && cur_v == 5) check("addr_8_5",  32'(framebuff_addr[3:0]), 32'd0);
            if (cur_h == 13 && cur_v == 8) check("addr_13_8", 32'(framebuff_addr[3:0]), 32'd7);
            if (cur_h == 15 && cur_v == 9) check("addr_15_9", 32'(framebuff_addr[3:0]), 32'd13);
            if (cur_h == 16 && cur_v == 9) check("addr_clip", 32'(framebuff_addr), 32'd0);
         end
         // Hsync period 24 px * 2 clk = 48, low 3 px * 2 clk = 6
         if (rst_m) begin
            have_fall = 0; low_valid = 0; gap = 0; low_cnt = 0;
         end else begin
            gap++;
            if (!Hsync_out && hs_prev) begin
               if (have_fall) check("hsync_period", 32'(gap), 32'd48);
               gap = 0; have_fall = 1; low_cnt = 1; low_valid = 1;
            end else if (!Hsync_out) begin
               low_cnt++;
            end else if (!hs_prev && low_valid) begin
               check("hsync_low", 32'(low_cnt), 32'd6);
            end
         end
         hs_prev = Hsync_out;
      end
   end

   // Stimulus: directed double swap request, random requests, one random mid-line reset
   initial begin
      int rst_at;
      rst = 1'b1;
      swap_req = 1'b0;
      rst_at = 1300 + int'($urandom_range(0, 100));
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (c < 700) swap_req = (c == 200) || (c == 260);
         else         swap_req = ($urandom_range(0, 39) == 0);
         rst = (c == rst_at) || (c == rst_at + 1);
      end
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
